sha_block_packer: RTL and testbench
===================================

// Module: sha_block_packer
// PURPOSE
//  Transmit side of the message-block stream consumed by wt_unit. It accepts raw message bytes as 64-bit big-endian AXI4-Stream words.
//  It applies SHA-2 padding: 0x80, zero fill, then the bit-length field.
//  It emits complete 512-bit (SHA-256) or 1024-bit (SHA-512/384) message blocks as 512-bit AXI4-Stream beats.
//  It sits between the host/DMA stream and the wt_unit slave port.
// PARAMETERS
//  P_S_AXIS_DATA_WIDTH  64   input word width in bits; only 64 is supported.
//  P_M_AXIS_DATA_WIDTH  512  output beat width in bits; only 512 is supported.
//  LEN_CNT_WIDTH        64   width of the message bit-length counter.
// PORTS
//  axi_aclk       in   1    clock; all logic on the rising edge.
//  axi_reset      in   1    asynchronous, active-high reset.
//  sha_type       in   2    00 = SHA-256; 01/1x = SHA-512/384. Sampled on the first accepted beat of each message.
//  en             in   1    engine enabled by scheduler; gates input acceptance only.
//  s_axis_tdata   in   64   message word; first byte is in [63:56].
//  s_axis_tkeep   in   8    byte valid, tkeep[7] maps to [63:56]. Must be 8'hFF except on tlast, where it is MSB-contiguous (8'h00 allowed).
//  s_axis_tvalid  in   1    input word valid.
//  s_axis_tready  out  1    input word accepted when high with tvalid.
//  s_axis_tlast   in   1    last word of the message.
//  m_axis_tdata   out  512  block beat; word 0 of the beat is in [511:448].
//  m_axis_tvalid  out  1    beat valid.
//  m_axis_tready  in   1    downstream ready.
//  m_axis_tlast   out  1    final beat of the final padded block of the message.
//  busy           out  1    high from the first accepted word until the final beat handshake.
// BEHAVIOUR
//  Reset: all outputs 0; state FILL; word_cnt 0; bit_len 0; buffer cleared.
//   Reset is asynchronous at any time and discards any partial message.
//  Block sizing: N = 8 words (1 beat) for SHA-256; N = 16 words (2 beats) for SHA-512.
//   SHA-512 sends beat 0 = words 0-7, then beat 1 = words 8-15.
//  Length field: 64-bit bit count for SHA-256, in word N-1.
//   128-bit bit count for SHA-512, in words N-2..N-1; the upper 64 bits are zero.
//  bit_len is incremented by 8*popcount(tkeep) per accepted word and wraps mod 2^64.
//  FSM:
//   FILL
//    - s_axis_tready = en.
//    - Each handshake writes buf[word_cnt] and increments word_cnt.
//    - Non-last word that fills the block: go to EMIT (mode = DATA).
//    - tlast word: write masked bytes, with 0x80 in the first byte after the valid bytes.
//     - If tkeep = 8'hFF, 0x80 is instead placed in the next word, written in PAD.
//     - Then go to PAD, or to EMIT if that word filled the block.
//   PAD
//    - s_axis_tready = 0; writes one word per cycle.
//    - Word content: pending 0x80 word, then zeros; length words at the reserved indices.
//    - Block full with length present: go to EMIT (mode = FINAL).
//    - If the 0x80 byte lands at or past the first length index, the current block is zero-completed and emitted (mode = PAD_MORE).
//     PAD then builds an extra block of zeros plus length.
//   EMIT
//    - m_axis_tvalid = 1; tdata is stable while tready is low.
//    - tlast = (mode == FINAL) and this is the last beat.
//    - After the last beat handshake:
//     - DATA goes to FILL.
//     - PAD_MORE goes to PAD with word_cnt = 0.
//     - FINAL goes to FILL with bit_len = 0 and busy = 0.
//  Latency: a block-completing word accepted or padded in cycle k gives m_axis_tvalid high in cycle k+1.
//  Throughput: no double buffer; a SHA-256 block takes 9 cycles minimum.
//  en low only stalls FILL; PAD and EMIT proceed. sha_type changes mid-message are ignored.
//  tlast and block-full on the same word: the word is stored, then EMIT (DATA or PAD_MORE), then PAD resumes with the pending 0x80.
// STRUCTURE
//  sha2_pkg:
//   - SHA_256/SHA_512 encodings.
//   - BLK_WORDS_256 = 8 and BLK_WORDS_512 = 16.
//   - FSM state and mode enums.
//   - The 0x80 pad constant.
//  Sub-module sha_pad_word: combinational; inputs tdata and tkeep.
//   Outputs: masked word with 0x80 inserted, a pad_next flag (tkeep = FF), and popcount.
//  The top level holds the FSM, a 16x64 buffer, word_cnt, bit_len and the output mux.
// TESTING
//  1. SHA-256 "abc": one word 0x6162630000000000, tkeep E0, tlast.
//     -> One beat, tlast = 1: word 0 = 0x6162638000000000, words 1-6 = 0, word 7 = 0x18.
//  2. SHA-256 56-byte message: 7 words, last tkeep FF.
//     -> Beat 1: msg + 0x8000000000000000, tlast = 0. Beat 2: zeros, word 7 = 0x1C0, tlast = 1.
//  3. SHA-512 "abc".
//     -> Beat 0: word 0 = 0x6162638000000000, rest 0, tlast = 0.
//        Beat 1: words 8-14 = 0, word 15 = 0x18, tlast = 1.
//  4. Test 1 with m_axis_tready low for 5 cycles during EMIT.
//     -> tdata/tvalid held constant, s_axis_tready = 0, identical beat delivered.
//  5. Assert axi_reset after 3 SHA-256 words, then send "abc".
//     -> Outputs and busy go to 0 asynchronously; result equals test 1 exactly.
//  6. Empty message: tlast with tkeep 00.
//     -> One beat: word 0 = 0x8000000000000000, all other words 0, tlast = 1.

Source files
------------

// File: rtl/sha2_pkg.sv
// Shared definitions for the SHA-2 message block packer.
//  - SHA variant encodings of the sha_type input
//  - block sizes in 64-bit words
//  - packer FSM state and emit-mode enums
//  - the padding byte that follows the last message byte
package sha2_pkg;

  localparam logic [1:0] SHA_256 = 2'b00;
  localparam logic [1:0] SHA_512 = 2'b01;

  localparam int unsigned BLK_WORDS_256 = 8;
  localparam int unsigned BLK_WORDS_512 = 16;

  localparam logic [7:0] PAD_BYTE = 8'h80;

  typedef enum logic [1:0] {
    StFill,
    StPad,
    StEmit
  } state_e;

  // What happens after the block currently being emitted.
  typedef enum logic [1:0] {
    ModeData,     // more message words follow: back to FILL
    ModePadMore,  // message ended but length did not fit: build another padded block
    ModeFinal     // block carries the length field: message done
  } mode_e;

endpackage

// File: rtl/sha_pad_word.sv
// Combinational helper for the last word of a message.
//  tdata    in   64  message word, first byte in [63:56]
//  tkeep    in   8   MSB-contiguous byte valid mask
//  word     out  64  valid bytes kept, 0x80 in the first invalid byte, zeros after
//  pad_next out  1   all bytes valid: the 0x80 byte must go into the following word
//  popcnt   out  4   number of valid bytes
module sha_pad_word
  import sha2_pkg::*;
(
  input  logic [63:0] tdata,
  input  logic [7:0]  tkeep,
  output logic [63:0] word,
  output logic        pad_next,
  output logic [3:0]  popcnt
);

  always_comb begin
    popcnt = '0;
    for (int i = 0; i < 8; i++) begin
      popcnt = popcnt + 4'(tkeep[i]);
    end
    word = '0;
    // Byte b = 0 is the first message byte; tkeep is MSB-contiguous so the first
    // invalid byte sits at position popcnt.
    for (int b = 0; b < 8; b++) begin
      if (tkeep[7-b]) begin
        word[63-8*b -: 8] = tdata[63-8*b -: 8];
      end else if (4'(b) == popcnt) begin
        word[63-8*b -: 8] = PAD_BYTE;
      end
    end
    pad_next = (tkeep == 8'hFF);
  end

endmodule

// File: rtl/sha_block_packer.sv
// Packs a byte stream of 64-bit big-endian words into SHA-2 padded message blocks
// and emits them as 512-bit beats (one beat per SHA-256 block, two per SHA-512 block).
//  axi_aclk/axi_reset        clock, asynchronous active-high reset
//  sha_type                  00 SHA-256, otherwise SHA-512/384; sampled on first word
//  en                        gates input acceptance only
//  s_axis_t{data,keep,valid,last}, s_axis_tready   message word input
//  m_axis_t{data,valid,last}, m_axis_tready        block beat output
//  busy                      first accepted word until final beat handshake
module sha_block_packer
  import sha2_pkg::*;
#(
  parameter int unsigned P_S_AXIS_DATA_WIDTH = 64,
  parameter int unsigned P_M_AXIS_DATA_WIDTH = 512,
  parameter int unsigned LEN_CNT_WIDTH       = 64
) (
  input  logic                             axi_aclk,
  input  logic                             axi_reset,
  input  logic [1:0]                       sha_type,
  input  logic                             en,
  input  logic [P_S_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [P_S_AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  input  logic                             s_axis_tlast,
  output logic [P_M_AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic                             m_axis_tlast,
  output logic                             busy
);

  state_e                   state_q, state_d;
  mode_e                    mode_q, mode_d;
  logic [3:0]               word_cnt_q, word_cnt_d;
  logic                     beat_q, beat_d;
  logic                     is512_q, is512_d;
  logic                     pad80_q, pad80_d;  // 0x80 word still owed
  logic                     more_q, more_d;    // current padded block cannot hold the length
  logic                     busy_q, busy_d;
  logic [LEN_CNT_WIDTH-1:0] bit_len_q, bit_len_d;
  logic [63:0]              blk_q [16];

  logic        wr_en;
  logic [63:0] wr_data;
  logic [63:0] pad_word;
  logic        pad_next;
  logic [3:0]  popcnt;
  logic        is512, fill_hs, more_now;
  logic [3:0]  last_idx, len_idx;

  sha_pad_word u_pad_word (
    .tdata    (s_axis_tdata),
    .tkeep    (s_axis_tkeep),
    .word     (pad_word),
    .pad_next (pad_next),
    .popcnt   (popcnt)
  );

  // Block size is taken live from sha_type on the first word of a message only.
  assign is512    = (state_q == StFill && !busy_q) ? (sha_type != SHA_256) : is512_q;
  assign last_idx = is512 ? 4'(BLK_WORDS_512 - 1) : 4'(BLK_WORDS_256 - 1);
  assign len_idx  = is512 ? 4'(BLK_WORDS_512 - 2) : 4'(BLK_WORDS_256 - 1);
  assign more_now = more_q || (pad80_q && word_cnt_q >= len_idx);

  assign s_axis_tready = (state_q == StFill) && en && !axi_reset;
  assign fill_hs       = s_axis_tready && s_axis_tvalid;

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    word_cnt_d = word_cnt_q;
    beat_d     = beat_q;
    is512_d    = is512_q;
    pad80_d    = pad80_q;
    more_d     = more_q;
    busy_d     = busy_q;
    bit_len_d  = bit_len_q;
    wr_en      = 1'b0;
    wr_data    = '0;
    unique case (state_q)
      StFill: begin
        if (fill_hs) begin
          wr_en      = 1'b1;
          busy_d     = 1'b1;
          is512_d    = is512;
          bit_len_d  = bit_len_q + LEN_CNT_WIDTH'({popcnt, 3'b000});
          word_cnt_d = word_cnt_q + 4'd1;
          if (s_axis_tlast) begin
            wr_data = pad_word;
            pad80_d = pad_next;
            more_d  = !pad_next && (word_cnt_q >= len_idx);
            if (word_cnt_q == last_idx) begin
              state_d    = StEmit;
              mode_d     = ModePadMore;
              word_cnt_d = '0;
              beat_d     = 1'b0;
            end else begin
              state_d = StPad;
            end
          end else begin
            wr_data = s_axis_tdata;
            if (word_cnt_q == last_idx) begin
              state_d    = StEmit;
              mode_d     = ModeData;
              word_cnt_d = '0;
              beat_d     = 1'b0;
            end
          end
        end
      end
      StPad: begin
        wr_en      = 1'b1;
        word_cnt_d = word_cnt_q + 4'd1;
        pad80_d    = 1'b0;
        more_d     = more_now;
        if (pad80_q) begin
          wr_data = {PAD_BYTE, 56'b0};
        end else if (!more_now && word_cnt_q == last_idx) begin
          // Upper 64 bits of the SHA-512 length are always zero, so only the
          // last word needs the count.
          wr_data = 64'(bit_len_q);
        end
        if (word_cnt_q == last_idx) begin
          state_d    = StEmit;
          mode_d     = more_now ? ModePadMore : ModeFinal;
          word_cnt_d = '0;
          beat_d     = 1'b0;
        end
      end
      StEmit: begin
        if (m_axis_tready) begin
          if (beat_q == is512_q) begin
            unique case (mode_q)
              ModeData:    state_d = StFill;
              ModePadMore: begin
                state_d = StPad;
                more_d  = 1'b0;
              end
              ModeFinal: begin
                state_d   = StFill;
                bit_len_d = '0;
                busy_d    = 1'b0;
              end
              default:     state_d = StFill;
            endcase
          end else begin
            beat_d = 1'b1;
          end
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      state_q    <= StFill;
      mode_q     <= ModeData;
      word_cnt_q <= '0;
      beat_q     <= 1'b0;
      is512_q    <= 1'b0;
      pad80_q    <= 1'b0;
      more_q     <= 1'b0;
      busy_q     <= 1'b0;
      bit_len_q  <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      word_cnt_q <= word_cnt_d;
      beat_q     <= beat_d;
      is512_q    <= is512_d;
      pad80_q    <= pad80_d;
      more_q     <= more_d;
      busy_q     <= busy_d;
      bit_len_q  <= bit_len_d;
    end
  end

  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      for (int i = 0; i < 16; i++) begin
        blk_q[i] <= '0;
      end
    end else if (wr_en) begin
      blk_q[word_cnt_q] <= wr_data;
    end
  end

  always_comb begin
    m_axis_tdata = '0;
    for (int i = 0; i < 8; i++) begin
      m_axis_tdata[511-64*i -: 64] = blk_q[{beat_q, 3'(i)}];
    end
  end

  assign m_axis_tvalid = (state_q == StEmit);
  assign m_axis_tlast  = m_axis_tvalid && (mode_q == ModeFinal) && (beat_q == is512_q);
  assign busy          = busy_q;

endmodule

// File: tb/tb_sha_block_packer.sv
module tb_sha_block_packer;

  logic         axi_aclk = 1'b0;
  logic         axi_reset = 1'b1;
  logic [1:0]   sha_type = 2'b00;
  logic         en = 1'b0;
  logic [63:0]  s_axis_tdata = '0;
  logic [7:0]   s_axis_tkeep = '0;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tready;
  logic         s_axis_tlast = 1'b0;
  logic [511:0] m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready = 1'b0;
  logic         m_axis_tlast;
  logic         busy;

  always #5 axi_aclk = ~axi_aclk;

  sha_block_packer dut (
    .axi_aclk      (axi_aclk),
    .axi_reset     (axi_reset),
    .sha_type      (sha_type),
    .en            (en),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .busy          (busy)
  );

  typedef struct packed {
    logic [1:0]          sha;
    logic [4:0]          nwords;
    logic [15:0][63:0]   data;
    logic [7:0]          keep;      // tkeep of the tlast word
    logic [1:0]          nbeats;
    logic [1:0][511:0]   exp;
    logic [1:0]          exp_last;
  } vec_t;

  localparam int NVEC = 7;
  vec_t tbl [NVEC];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] w(input int i);
    return 64'h1111111111111111 * 64'(i + 1);
  endfunction

  task automatic send_vec(input vec_t v, input string tag);
    int t;
    sha_type = v.sha;
    for (int i = 0; i < int'(v.nwords); i++) begin
      s_axis_tdata  = v.data[i];
      s_axis_tlast  = (i == int'(v.nwords) - 1);
      s_axis_tkeep  = s_axis_tlast ? v.keep : 8'hFF;
      s_axis_tvalid = 1'b1;
      t = 0;
      @(negedge axi_aclk);
      while (!s_axis_tready && t < 200) begin
        @(negedge axi_aclk);
        t++;
      end
      if (!s_axis_tready) begin
        n_cmp++;
        n_fail++;
        $display("FAIL %s send word %0d: tready low after %0d cycles, expected high", tag, i, t);
      end
      @(posedge axi_aclk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic recv_vec(input vec_t v, input string tag);
    int t;
    m_axis_tready = 1'b1;
    for (int b = 0; b < int'(v.nbeats); b++) begin
      t = 0;
      @(negedge axi_aclk);
      while (!m_axis_tvalid && t < 400) begin
        @(negedge axi_aclk);
        t++;
      end
      if (!m_axis_tvalid) begin
        n_cmp++;
        n_fail++;
        $display("FAIL %s beat %0d: tvalid low after %0d cycles, expected high", tag, b, t);
        return;
      end
      check($sformatf("%s beat%0d tdata", tag, b), m_axis_tdata, v.exp[b]);
      check($sformatf("%s beat%0d tlast", tag, b), 512'(m_axis_tlast), 512'(v.exp_last[b]));
      @(posedge axi_aclk);
      #1;
    end
    check($sformatf("%s busy after", tag), 512'(busy), 512'(0));
    check($sformatf("%s tvalid after", tag), 512'(m_axis_tvalid), 512'(0));
  endtask

  initial begin
    int t;
    for (int k = 0; k < NVEC; k++) tbl[k] = '0;

    // SHA-256 "abc"
    tbl[0].sha = 2'b00; tbl[0].nwords = 1; tbl[0].keep = 8'hE0; tbl[0].nbeats = 1;
    tbl[0].data[0] = 64'h6162630000000000;
    tbl[0].exp[0] = {64'h6162638000000000, 384'b0, 64'h18};
    tbl[0].exp_last = 2'b01;
    // SHA-256 56 bytes: 0x80 spills into a block with no room for the length
    tbl[1].sha = 2'b00; tbl[1].nwords = 7; tbl[1].keep = 8'hFF; tbl[1].nbeats = 2;
    for (int i = 0; i < 7; i++) tbl[1].data[i] = w(i);
    tbl[1].exp[0] = {w(0), w(1), w(2), w(3), w(4), w(5), w(6), 64'h8000000000000000};
    tbl[1].exp[1] = {448'b0, 64'h1C0};
    tbl[1].exp_last = 2'b10;
    // SHA-512 "abc" with the 1x encoding
    tbl[2].sha = 2'b10; tbl[2].nwords = 1; tbl[2].keep = 8'hE0; tbl[2].nbeats = 2;
    tbl[2].data[0] = 64'h6162630000000000;
    tbl[2].exp[0] = {64'h6162638000000000, 448'b0};
    tbl[2].exp[1] = {448'b0, 64'h18};
    tbl[2].exp_last = 2'b10;
    // Empty message; data bytes are all masked off
    tbl[3].sha = 2'b00; tbl[3].nwords = 1; tbl[3].keep = 8'h00; tbl[3].nbeats = 1;
    tbl[3].data[0] = 64'hDEADBEEFCAFEF00D;
    tbl[3].exp[0] = {64'h8000000000000000, 448'b0};
    tbl[3].exp_last = 2'b01;
    // SHA-256 64 bytes: tlast fills the block, 0x80 opens the next one
    tbl[4].sha = 2'b00; tbl[4].nwords = 8; tbl[4].keep = 8'hFF; tbl[4].nbeats = 2;
    for (int i = 0; i < 8; i++) tbl[4].data[i] = w(i);
    tbl[4].exp[0] = {w(0), w(1), w(2), w(3), w(4), w(5), w(6), w(7)};
    tbl[4].exp[1] = {64'h8000000000000000, 384'b0, 64'h200};
    tbl[4].exp_last = 2'b10;
    // SHA-256 60 bytes: 0x80 inside the last word of the block
    tbl[5].sha = 2'b00; tbl[5].nwords = 8; tbl[5].keep = 8'hF0; tbl[5].nbeats = 2;
    for (int i = 0; i < 8; i++) tbl[5].data[i] = w(i);
    tbl[5].exp[0] = {w(0), w(1), w(2), w(3), w(4), w(5), w(6), 64'h8888888880000000};
    tbl[5].exp[1] = {448'b0, 64'h1E0};
    tbl[5].exp_last = 2'b10;
    // SHA-512 72 bytes
    tbl[6].sha = 2'b11; tbl[6].nwords = 9; tbl[6].keep = 8'hFF; tbl[6].nbeats = 2;
    for (int i = 0; i < 9; i++) tbl[6].data[i] = w(i);
    tbl[6].exp[0] = {w(0), w(1), w(2), w(3), w(4), w(5), w(6), w(7)};
    tbl[6].exp[1] = {w(8), 64'h8000000000000000, 320'b0, 64'h240};
    tbl[6].exp_last = 2'b10;

    en = 1'b1;
    repeat (2) @(posedge axi_aclk);
    #1;
    check("reset tvalid", 512'(m_axis_tvalid), 512'(0));
    check("reset tlast", 512'(m_axis_tlast), 512'(0));
    check("reset tdata", m_axis_tdata, 512'(0));
    check("reset busy", 512'(busy), 512'(0));
    check("reset s_tready", 512'(s_axis_tready), 512'(0));
    axi_reset = 1'b0;
    #1;
    check("idle s_tready", 512'(s_axis_tready), 512'(1));
    en = 1'b0;
    #1;
    check("en low s_tready", 512'(s_axis_tready), 512'(0));
    en = 1'b1;
    @(posedge axi_aclk);
    #1;

    for (int k = 0; k < NVEC; k++) begin
      fork
        send_vec(tbl[k], $sformatf("vec%0d", k));
        recv_vec(tbl[k], $sformatf("vec%0d", k));
      join
      @(posedge axi_aclk);
      #1;
    end

    // Output stall: beat must hold while m_axis_tready is low
    m_axis_tready = 1'b0;
    send_vec(tbl[0], "stall");
    t = 0;
    do begin
      @(negedge axi_aclk);
      t++;
    end while (!m_axis_tvalid && t < 50);
    check("stall latency", 512'(t), 512'(8));
    for (int c = 0; c < 5; c++) begin
      check($sformatf("stall%0d tdata", c), m_axis_tdata, tbl[0].exp[0]);
      check($sformatf("stall%0d tvalid", c), 512'(m_axis_tvalid), 512'(1));
      check($sformatf("stall%0d s_tready", c), 512'(s_axis_tready), 512'(0));
      @(negedge axi_aclk);
    end
    check("stall release tdata", m_axis_tdata, tbl[0].exp[0]);
    check("stall release tlast", 512'(m_axis_tlast), 512'(1));
    m_axis_tready = 1'b1;
    @(posedge axi_aclk);
    #1;
    check("stall busy after", 512'(busy), 512'(0));
    check("stall tvalid after", 512'(m_axis_tvalid), 512'(0));

    // Mid-message asynchronous reset, then a clean "abc"
    sha_type = 2'b00;
    for (int i = 0; i < 3; i++) begin
      s_axis_tdata  = w(i);
      s_axis_tkeep  = 8'hFF;
      s_axis_tlast  = 1'b0;
      s_axis_tvalid = 1'b1;
      @(posedge axi_aclk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    check("pre-reset busy", 512'(busy), 512'(1));
    #2;
    axi_reset = 1'b1;
    #1;
    check("async reset busy", 512'(busy), 512'(0));
    check("async reset tvalid", 512'(m_axis_tvalid), 512'(0));
    check("async reset tdata", m_axis_tdata, 512'(0));
    @(posedge axi_aclk);
    #1;
    axi_reset = 1'b0;
    @(posedge axi_aclk);
    #1;
    fork
      send_vec(tbl[0], "post-reset");
      recv_vec(tbl[0], "post-reset");
    join

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
